// File: rtl/cdb_pkg.sv
// Shared types for the common data bus arbiter: tag width, broadcast entry, source id.
// No logic; imported by the FIFO, interface and arbiter.
// No backpressure of its own.
package cdb_pkg;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag_PRF;
        logic [TAG_W-1:0] tag_ROB;
    } cdb_entry_t;

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } cdb_src_e;

    function automatic cdb_src_e other_src(input cdb_src_e s);
        return (s == SRC_ADD) ? SRC_MUL : SRC_ADD;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshakes from the add/mul units plus the registered CDB broadcast.
// Latency n/a (wiring only).
// ready_add/ready_mul are the only backpressure, driven by the arbiter.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             valid_add_in;
    logic [TAG_W-1:0] tag_PRF_add_in;
    logic [TAG_W-1:0] tag_ROB_add_in;
    logic             ready_add;

    logic             valid_mul_in;
    logic [TAG_W-1:0] tag_PRF_mul_in;
    logic [TAG_W-1:0] tag_ROB_mul_in;
    logic             ready_mul;

    logic             valid_Result_cdb;
    logic [TAG_W-1:0] tag_PRF_cdb;
    logic [TAG_W-1:0] tag_ROB_cdb;
    logic             src_cdb;
    logic [CNT_W-1:0] contention_cnt;

    modport slave (
        input  valid_add_in, tag_PRF_add_in, tag_ROB_add_in,
        input  valid_mul_in, tag_PRF_mul_in, tag_ROB_mul_in,
        output ready_add, ready_mul,
        output valid_Result_cdb, tag_PRF_cdb, tag_ROB_cdb, src_cdb, contention_cnt
    );

    modport master (
        output valid_add_in, tag_PRF_add_in, tag_ROB_add_in,
        output valid_mul_in, tag_PRF_mul_in, tag_ROB_mul_in,
        input  ready_add, ready_mul,
        input  valid_Result_cdb, tag_PRF_cdb, tag_ROB_cdb, src_cdb, contention_cnt
    );

endinterface

// File: rtl/cdb_fifo.sv
// Small per-unit result queue; head is visible combinationally.
// Latency: push at edge t readable as head after edge t.
// full refuses pushes (even on a same-edge pop); flush empties synchronously.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t push_dat,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    cdb_entry_t       mem_q [DEPTH];
    cdb_entry_t       mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of the CDB between add and mul result queues.
// Latency: push at edge t broadcast at edge t+1 earliest, one result per cycle.
// ready_* = !full per queue; stop flushes queues and the broadcast register.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stop,
    cdb_arbiter_if.slave  bus
);

    logic       full_add, empty_add, pop_add;
    logic       full_mul, empty_mul, pop_mul;
    cdb_entry_t head_add, head_mul;
    cdb_entry_t push_add_dat, push_mul_dat;

    logic             vld_q, vld_d;
    cdb_entry_t       ent_q, ent_d;
    cdb_src_e         src_q, src_d;
    cdb_src_e         rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic any_rdy, contested, grant_mul;

    assign push_add_dat = '{tag_PRF: bus.tag_PRF_add_in, tag_ROB: bus.tag_ROB_add_in};
    assign push_mul_dat = '{tag_PRF: bus.tag_PRF_mul_in, tag_ROB: bus.tag_ROB_mul_in};

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo_add (
        .clk      (clk),
        .rst      (rst),
        .flush    (stop),
        .push     (bus.valid_add_in),
        .push_dat (push_add_dat),
        .pop      (pop_add),
        .full     (full_add),
        .empty    (empty_add),
        .head     (head_add)
    );

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo_mul (
        .clk      (clk),
        .rst      (rst),
        .flush    (stop),
        .push     (bus.valid_mul_in),
        .push_dat (push_mul_dat),
        .pop      (pop_mul),
        .full     (full_mul),
        .empty    (empty_mul),
        .head     (head_mul)
    );

    assign any_rdy   = ~empty_add | ~empty_mul;
    assign contested = ~empty_add & ~empty_mul;
    assign grant_mul = contested ? (rr_q == SRC_MUL) : ~empty_mul;

    always_comb begin
        pop_add = 1'b0;
        pop_mul = 1'b0;
        vld_d   = 1'b0;
        ent_d   = '0;
        src_d   = SRC_ADD;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (stop) begin
            rr_d = SRC_ADD;
        end else if (any_rdy) begin
            vld_d = 1'b1;
            if (grant_mul) begin
                pop_mul = 1'b1;
                ent_d   = head_mul;
                src_d   = SRC_MUL;
            end else begin
                pop_add = 1'b1;
                ent_d   = head_add;
            end
            // Priority only moves when both queues competed for the bus.
            if (contested) begin
                rr_d = other_src(rr_q);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            ent_q <= '0;
            src_q <= SRC_ADD;
            rr_q  <= SRC_ADD;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
            src_q <= src_d;
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ready_add        = ~full_add;
    assign bus.ready_mul        = ~full_mul;
    assign bus.valid_Result_cdb = vld_q;
    assign bus.tag_PRF_cdb      = ent_q.tag_PRF;
    assign bus.tag_ROB_cdb      = ent_q.tag_ROB;
    assign bus.src_cdb          = src_q;
    assign bus.contention_cnt   = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter built with DEPTH=2, CNT_W=4.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_cdb_arbiter;

    localparam int TW = 4;
    localparam int CW = 4;

    logic clk;
    logic rst;
    logic stop;
    int   checks;
    int   errors;

    cdb_arbiter_if #(.CNT_W(CW)) bus ();

    cdb_arbiter #(.DEPTH(2), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .stop (stop),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_add(input logic v, input logic [TW-1:0] p, input logic [TW-1:0] r);
        bus.valid_add_in   = v;
        bus.tag_PRF_add_in = p;
        bus.tag_ROB_add_in = r;
    endtask

    task automatic drive_mul(input logic v, input logic [TW-1:0] p, input logic [TW-1:0] r);
        bus.valid_mul_in   = v;
        bus.tag_PRF_mul_in = p;
        bus.tag_ROB_mul_in = r;
    endtask

    task automatic idle();
        drive_add(1'b0, '0, '0);
        drive_mul(1'b0, '0, '0);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", bus.valid_Result_cdb); end
        checks++; if (bus.tag_PRF_cdb !== 4'd0) begin errors++; $display("FAIL rst_prf got %0d exp 0", bus.tag_PRF_cdb); end
        checks++; if (bus.tag_ROB_cdb !== 4'd0) begin errors++; $display("FAIL rst_rob got %0d exp 0", bus.tag_ROB_cdb); end
        checks++; if (bus.src_cdb !== 1'b0) begin errors++; $display("FAIL rst_src got %0d exp 0", bus.src_cdb); end
        checks++; if (bus.contention_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.contention_cnt); end
        checks++; if (bus.ready_add !== 1'b1 || bus.ready_mul !== 1'b1) begin errors++; $display("FAIL rst_ready got %0d%0d exp 11", bus.ready_add, bus.ready_mul); end
        rst = 1'b0;
        tick();
        checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %0d exp 0", bus.valid_Result_cdb); end
    endtask

    task automatic test_single();
        drive_add(1'b1, 4'd5, 4'd2);
        tick();
        idle();
        checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL single_nobypass got %0d exp 0", bus.valid_Result_cdb); end
        tick();
        checks++; if (bus.valid_Result_cdb !== 1'b1) begin errors++; $display("FAIL single_valid got %0d exp 1", bus.valid_Result_cdb); end
        checks++; if (bus.tag_PRF_cdb !== 4'd5) begin errors++; $display("FAIL single_prf got %0d exp 5", bus.tag_PRF_cdb); end
        checks++; if (bus.tag_ROB_cdb !== 4'd2) begin errors++; $display("FAIL single_rob got %0d exp 2", bus.tag_ROB_cdb); end
        checks++; if (bus.src_cdb !== 1'b0) begin errors++; $display("FAIL single_src got %0d exp 0", bus.src_cdb); end
        tick();
        checks++; if (bus.valid_Result_cdb !== 1'b0 || bus.tag_PRF_cdb !== 4'd0) begin errors++; $display("FAIL single_after got v%0d p%0d exp v0 p0", bus.valid_Result_cdb, bus.tag_PRF_cdb); end
    endtask

    task automatic test_contention();
        drive_add(1'b1, 4'd3, 4'd1);
        drive_mul(1'b1, 4'd7, 4'd4);
        tick();
        idle();
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd3 || bus.tag_ROB_cdb !== 4'd1 || bus.src_cdb !== 1'b0) begin errors++; $display("FAIL cont_first got p%0d r%0d s%0d exp p3 r1 s0", bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        checks++; if (bus.contention_cnt !== 4'd1) begin errors++; $display("FAIL cont_cnt1 got %0d exp 1", bus.contention_cnt); end
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd7 || bus.tag_ROB_cdb !== 4'd4 || bus.src_cdb !== 1'b1) begin errors++; $display("FAIL cont_second got p%0d r%0d s%0d exp p7 r4 s1", bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        checks++; if (bus.contention_cnt !== 4'd1) begin errors++; $display("FAIL cont_cnt_hold got %0d exp 1", bus.contention_cnt); end
        tick();
        checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL cont_drained got %0d exp 0", bus.valid_Result_cdb); end
        drive_add(1'b1, 4'd1, 4'd9);
        drive_mul(1'b1, 4'd2, 4'd10);
        tick();
        idle();
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd2 || bus.src_cdb !== 1'b1) begin errors++; $display("FAIL cont_rr_mul got p%0d s%0d exp p2 s1", bus.tag_PRF_cdb, bus.src_cdb); end
        checks++; if (bus.contention_cnt !== 4'd2) begin errors++; $display("FAIL cont_cnt2 got %0d exp 2", bus.contention_cnt); end
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd1 || bus.tag_ROB_cdb !== 4'd9 || bus.src_cdb !== 1'b0) begin errors++; $display("FAIL cont_rr_add got p%0d r%0d s%0d exp p1 r9 s0", bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        tick();
    endtask

    task automatic test_full();
        drive_add(1'b1, 4'd10, 4'd1);
        drive_mul(1'b1, 4'd11, 4'd2);
        tick();
        checks++; if (bus.ready_mul !== 1'b1) begin errors++; $display("FAIL full_ready_one got %0d exp 1", bus.ready_mul); end
        drive_add(1'b1, 4'd12, 4'd3);
        drive_mul(1'b1, 4'd13, 4'd4);
        tick();
        checks++; if (bus.ready_mul !== 1'b0) begin errors++; $display("FAIL full_ready_two got %0d exp 0", bus.ready_mul); end
        checks++; if (bus.tag_PRF_cdb !== 4'd10 || bus.src_cdb !== 1'b0 || bus.contention_cnt !== 4'd3) begin errors++; $display("FAIL full_b0 got p%0d s%0d c%0d exp p10 s0 c3", bus.tag_PRF_cdb, bus.src_cdb, bus.contention_cnt); end
        drive_add(1'b0, '0, '0);
        drive_mul(1'b1, 4'd14, 4'd5);
        tick();
        idle();
        checks++; if (bus.tag_PRF_cdb !== 4'd11 || bus.tag_ROB_cdb !== 4'd2 || bus.src_cdb !== 1'b1) begin errors++; $display("FAIL full_b1 got p%0d r%0d s%0d exp p11 r2 s1", bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        checks++; if (bus.ready_mul !== 1'b1 || bus.contention_cnt !== 4'd4) begin errors++; $display("FAIL full_reopen got r%0d c%0d exp r1 c4", bus.ready_mul, bus.contention_cnt); end
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd12 || bus.src_cdb !== 1'b0 || bus.contention_cnt !== 4'd5) begin errors++; $display("FAIL full_b2 got p%0d s%0d c%0d exp p12 s0 c5", bus.tag_PRF_cdb, bus.src_cdb, bus.contention_cnt); end
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd13 || bus.tag_ROB_cdb !== 4'd4 || bus.src_cdb !== 1'b1) begin errors++; $display("FAIL full_b3 got p%0d r%0d s%0d exp p13 r4 s1", bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        tick();
        checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL full_dropped got %0d exp 0", bus.valid_Result_cdb); end
    endtask

    task automatic test_flush();
        drive_add(1'b1, 4'd4, 4'd6);
        drive_mul(1'b1, 4'd8, 4'd12);
        tick();
        drive_add(1'b1, 4'd9, 4'd3);
        drive_mul(1'b1, 4'd1, 4'd13);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        idle();
        checks++; if (bus.valid_Result_cdb !== 1'b0 || bus.tag_PRF_cdb !== 4'd0 || bus.tag_ROB_cdb !== 4'd0 || bus.src_cdb !== 1'b0) begin errors++; $display("FAIL flush_out got v%0d p%0d r%0d s%0d exp all 0", bus.valid_Result_cdb, bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        checks++; if (bus.ready_add !== 1'b1 || bus.ready_mul !== 1'b1) begin errors++; $display("FAIL flush_ready got %0d%0d exp 11", bus.ready_add, bus.ready_mul); end
        checks++; if (bus.contention_cnt !== 4'd5) begin errors++; $display("FAIL flush_cnt got %0d exp 5", bus.contention_cnt); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL flush_stale%0d got %0d exp 0", i, bus.valid_Result_cdb); end
        end
        drive_add(1'b1, 4'd6, 4'd7);
        drive_mul(1'b1, 4'd13, 4'd14);
        tick();
        idle();
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd6 || bus.src_cdb !== 1'b0 || bus.contention_cnt !== 4'd6) begin errors++; $display("FAIL flush_rr got p%0d s%0d c%0d exp p6 s0 c6", bus.tag_PRF_cdb, bus.src_cdb, bus.contention_cnt); end
        tick();
        checks++; if (bus.tag_PRF_cdb !== 4'd13 || bus.tag_ROB_cdb !== 4'd14 || bus.src_cdb !== 1'b1) begin errors++; $display("FAIL flush_next got p%0d r%0d s%0d exp p13 r14 s1", bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        tick();
    endtask

    task automatic test_saturation();
        int vld_seen;
        vld_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive_add(1'b1, TW'(i), TW'(i + 1));
            drive_mul(1'b1, TW'(15 - i), TW'(i + 2));
            tick();
            if (bus.valid_Result_cdb === 1'b1) vld_seen++;
        end
        idle();
        repeat (4) tick();
        checks++; if (vld_seen !== 19) begin errors++; $display("FAIL sat_rate got %0d exp 19", vld_seen); end
        checks++; if (bus.contention_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", bus.contention_cnt); end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 3; i++) begin
            drive_add(1'b1, TW'(i + 3), TW'(i));
            drive_mul(1'b1, TW'(i + 8), TW'(i + 1));
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.valid_Result_cdb !== 1'b0 || bus.tag_PRF_cdb !== 4'd0 || bus.tag_ROB_cdb !== 4'd0 || bus.src_cdb !== 1'b0) begin errors++; $display("FAIL mrst_out got v%0d p%0d r%0d s%0d exp all 0", bus.valid_Result_cdb, bus.tag_PRF_cdb, bus.tag_ROB_cdb, bus.src_cdb); end
        checks++; if (bus.contention_cnt !== 4'd0) begin errors++; $display("FAIL mrst_cnt got %0d exp 0", bus.contention_cnt); end
        checks++; if (bus.ready_add !== 1'b1 || bus.ready_mul !== 1'b1) begin errors++; $display("FAIL mrst_ready got %0d%0d exp 11", bus.ready_add, bus.ready_mul); end
        tick();
        rst = 1'b0;
        idle();
        tick();
        checks++; if (bus.valid_Result_cdb !== 1'b0) begin errors++; $display("FAIL mrst_empty got %0d exp 0", bus.valid_Result_cdb); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stop   = 1'b0;
        idle();
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_flush();
        test_saturation();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
